// File: rtl/cpu_pkg.sv
// Phase encoding, opcode constants and small helpers shared by the cpu_ctrl sequencer.
// Used by cpu_ctrl and cpu_ctrl_decode; the optional CPU_CTRL_WAIT_EN build uses op_reads_mem.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    EXEC_A = 2'b10,
    EXEC_B = 2'b11
  } phase_t;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_NAND  = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b011;
  localparam logic [2:0] OP_LD    = 3'b100;
  localparam logic [2:0] OP_ST    = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_BZ    = 3'b111;

  localparam logic [4:0] SHIFT_RIGHT_OPERAND = 5'h1f;

  // Opcodes whose EXEC_A phase fetches an operand from memory.
  function automatic logic op_reads_mem(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) || (op == OP_LD);
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Moore strobe decode for the sequencer: {phase, opcode} -> memory and ALU control strobes.
// i_ready gates the ALU/accumulator loads of memory-reading ops; tie high when memory is single-cycle.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  phase_t     i_state,
  input  logic [2:0] i_opcode,
  input  logic       i_ready,
  input  logic       i_reset,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic       o_ld_acc,
  output logic       o_use_alu,
  output logic       o_dbus_sel
);

  always_comb begin
    o_mem_rd   = 1'b0;
    o_mem_wr   = 1'b0;
    o_ld_acc   = 1'b0;
    o_use_alu  = 1'b0;
    o_dbus_sel = 1'b0;
    if (!i_reset) begin
      unique case (i_state)
        FETCH: o_mem_rd = 1'b1;
        DECODE: begin
        end
        EXEC_A: begin
          case (i_opcode)
            OP_ADD, OP_SUB, OP_NAND: begin
              o_mem_rd  = 1'b1;
              o_use_alu = i_ready;
            end
            OP_SHIFT: o_use_alu = 1'b1;
            OP_LD: begin
              o_mem_rd = 1'b1;
              o_ld_acc = i_ready;
            end
            OP_ST:    o_use_alu = 1'b1;
            default: begin
            end
          endcase
        end
        EXEC_B: begin
          // The ALU drives d_bus here, so mem_rd must stay low in this phase.
          case (i_opcode)
            OP_ADD, OP_SUB, OP_NAND, OP_SHIFT: begin
              o_dbus_sel = 1'b1;
              o_ld_acc   = 1'b1;
            end
            OP_ST: begin
              o_dbus_sel = 1'b1;
              o_mem_wr   = 1'b1;
            end
            default: begin
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Four-phase instruction sequencer: holds PC and instruction register, resolves JMP/BZ.
// Define CPU_CTRL_WAIT_EN to add the mem_ready handshake that stretches memory phases.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          tclk,
  input  logic          reset,
  input  logic [DW-1:0] d_bus,
  input  logic          c,
  input  logic          z,
`ifdef CPU_CTRL_WAIT_EN
  input  logic          mem_ready,
`endif
  output logic [DW-1:0] instruction,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          ldAcc,
  output logic          useAlu,
  output logic          dbusSelect,
  output logic [1:0]    state
);

  phase_t        r_state;
  phase_t        w_state_next;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_next;
  logic [DW-1:0] r_instr;
  logic [DW-1:0] w_instr_next;
  logic [2:0]    w_opcode;
  logic [AW-1:0] w_operand;
  logic          w_ready;
  logic          w_hold;
  logic          w_unused_carry;

  assign w_opcode       = r_instr[DW-1:DW-3];
  assign w_operand      = r_instr[AW-1:0];
  // Carry only matters to the ALU; BZ is the sole flag-driven branch.
  assign w_unused_carry = c;

`ifdef CPU_CTRL_WAIT_EN
  assign w_ready = mem_ready;

  always_comb begin
    w_hold = 1'b0;
    case (r_state)
      FETCH:   w_hold = !w_ready;
      EXEC_A:  w_hold = op_reads_mem(w_opcode) && !w_ready;
      EXEC_B:  w_hold = (w_opcode == OP_ST) && !w_ready;
      default: w_hold = 1'b0;
    endcase
  end
`else
  assign w_ready = 1'b1;
  assign w_hold  = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    if (!w_hold) begin
      unique case (r_state)
        FETCH: begin
          w_instr_next = d_bus;
          w_pc_next    = r_pc + AW'(1);
          w_state_next = DECODE;
        end
        DECODE: w_state_next = EXEC_A;
        EXEC_A: begin
          // Branch target overwrites the increment already applied in FETCH.
          if ((w_opcode == OP_JMP) || ((w_opcode == OP_BZ) && z)) begin
            w_pc_next = w_operand;
          end
          w_state_next = EXEC_B;
        end
        EXEC_B: w_state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge tclk) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
    end
  end

  cpu_ctrl_decode u_decode (
    .i_state    (r_state),
    .i_opcode   (w_opcode),
    .i_ready    (w_ready),
    .i_reset    (reset),
    .o_mem_rd   (mem_rd),
    .o_mem_wr   (mem_wr),
    .o_ld_acc   (ldAcc),
    .o_use_alu  (useAlu),
    .o_dbus_sel (dbusSelect)
  );

  assign instruction = r_instr;
  assign pc          = r_pc;
  assign addr        = (r_state == FETCH) ? r_pc : w_operand;
  assign state       = r_state;

endmodule
